// File: rtl/ifetch_line_unit.sv
// Line-buffered instruction fetch: one AXI INCR burst per aligned line, then streams words to decode.
// Define IFETCH_HALT_ON_ZERO_EN to stop fetching (halted=1) when a zero instruction word is reached.
module ifetch_line_unit #(
    parameter int                  ID_WIDTH   = 13,
    parameter int                  ADDR_WIDTH = 64,
    parameter int                  DATA_WIDTH = 64,
    parameter int                  LINE_BYTES = 64,
    parameter logic [ID_WIDTH-1:0] FETCH_ID   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] entry,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [31:0]           inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  halted,
    output logic                  fault
);
    localparam int BEATS = LINE_BYTES * 8 / DATA_WIDTH;
    localparam int WORDS = LINE_BYTES / 4;
    localparam int WPB   = DATA_WIDTH / 32;
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int WIW   = $clog2(WORDS);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_FILL, S_DRAIN, S_SERVE, S_HALT} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] tag_q, tag_d;
    logic                  tag_valid_q, tag_valid_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic                  err_q, err_d;
    logic                  fault_q, fault_d;
    logic [31:0]           line_mem [WORDS];

    logic [ADDR_WIDTH-1:0] line_mask, redir_pc, pc_inc;
    logic                  ar_fire, r_own, r_last, redir_hit, wrap, zero_word;
    logic [31:0]           cur_word;

    assign line_mask = ~ADDR_WIDTH'(LINE_BYTES - 1);
    assign redir_pc  = redirect_pc & ~ADDR_WIDTH'(3);
    assign redir_hit = tag_valid_q && ((redir_pc & line_mask) == tag_q);
    assign pc_inc    = pc_q + ADDR_WIDTH'(4);
    assign wrap      = (pc_inc[OFF_W-1:0] == '0);
    assign ar_fire   = m_axi_arvalid && m_axi_arready;
    // Beats tagged with another ID belong to someone else: accepted but ignored.
    assign r_own     = m_axi_rvalid && (m_axi_rid == FETCH_ID);
    assign r_last    = r_own && m_axi_rlast;
    assign cur_word  = line_mem[pc_q[OFF_W-1:2]];

`ifdef IFETCH_HALT_ON_ZERO_EN
    assign zero_word = (cur_word == 32'h0);
`else
    assign zero_word = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= entry;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
            beat_q      <= '0;
            err_q       <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
            beat_q      <= beat_d;
            err_q       <= err_d;
            fault_q     <= fault_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_FILL && r_own) begin
            for (int w = 0; w < WPB; w++) begin
                line_mem[WIW'(int'(beat_q) * WPB + w)] <= m_axi_rdata[w*32 +: 32];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tag_d       = tag_q;
        tag_valid_d = tag_valid_q;
        beat_d      = beat_q;
        err_d       = err_q;
        fault_d     = fault_q;
        case (state_q)
            S_IDLE: begin
                if (redirect_valid) pc_d = redir_pc;
                state_d = S_REQ;
            end
            S_REQ: begin
                if (redirect_valid) pc_d = redir_pc;
                // A redirect racing the address handshake leaves a stale burst to drain.
                if (ar_fire) begin
                    beat_d      = '0;
                    err_d       = 1'b0;
                    tag_valid_d = 1'b0;
                    state_d     = redirect_valid ? S_DRAIN : S_FILL;
                end
            end
            S_FILL: begin
                if (r_own) begin
                    beat_d = beat_q + BW'(1);
                    if (m_axi_rresp != 2'b00) err_d = 1'b1;
                end
                if (redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = r_last ? S_REQ : S_DRAIN;
                end else if (r_last) begin
                    if (err_q || m_axi_rresp != 2'b00) begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        tag_d       = pc_q & line_mask;
                        tag_valid_d = 1'b1;
                        state_d     = S_SERVE;
                    end
                end
            end
            S_DRAIN: begin
                if (redirect_valid) pc_d = redir_pc;
                if (r_last) state_d = S_REQ;
            end
            S_SERVE: begin
                if (redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = redir_hit ? S_SERVE : S_REQ;
                end else if (zero_word) begin
                    state_d = S_HALT;
                end else if (inst_ready) begin
                    pc_d = pc_inc;
                    if (wrap) state_d = S_REQ;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        m_axi_arvalid = (state_q == S_REQ);
        m_axi_rready  = (state_q == S_FILL) || (state_q == S_DRAIN);
        inst_valid    = (state_q == S_SERVE) && !zero_word;
        fault         = (state_q == S_HALT) && fault_q;
`ifdef IFETCH_HALT_ON_ZERO_EN
        halted        = (state_q == S_HALT) && !fault_q;
`else
        halted        = 1'b0;
`endif
    end

    assign m_axi_arid    = FETCH_ID;
    assign m_axi_araddr  = pc_q & line_mask;
    assign m_axi_arlen   = 8'(BEATS - 1);
    assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m_axi_arburst = 2'b01;
    assign inst          = cur_word;
    assign inst_pc       = pc_q;

endmodule

// File: tb/tb_ifetch_line_unit.sv
// Bench for ifetch_line_unit: AXI slave model, instruction scoreboard, vector table plus corner sequences.
module tb_ifetch_line_unit;
    localparam int BEATS = 8;
    localparam int LB    = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] entry;
    logic [12:0] arid;
    logic [63:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [12:0] rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic        inst_valid, inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halted, fault;

    always #5 clk = ~clk;

    ifetch_line_unit #(.ID_WIDTH(13), .ADDR_WIDTH(64), .DATA_WIDTH(64), .LINE_BYTES(LB), .FETCH_ID(13'd0)) dut (
        .clk(clk), .reset(reset), .entry(entry),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted), .fault(fault)
    );

    typedef struct { logic [63:0] pc; logic [31:0] ins; } exp_t;
    typedef struct { logic [63:0] entry; int n; logic [63:0] ar0; logic [63:0] ar1; int arwait; } vec_t;

    exp_t        sb[$];
    logic [63:0] ar_log[$];
    int          beats_at_ar[$];
    int          tests = 0, fails = 0;
    int          accepts = 0, beats_total = 0, viol = 0;
    logic [63:0] zero_addr;
    int          err_beat, ar_wait;
    logic [7:0]  last_len;
    logic [2:0]  last_size;
    logic [1:0]  last_burst;
    logic [12:0] last_id;
    bit          active = 1'b0;
    int          b_beat = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == zero_addr) return 32'h0;
        return 32'h13 + 32'((a - 64'h1000) >> 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // AXI read slave: decisions sampled mid-cycle, new drive values applied just after the edge.
    initial begin
        bit          ar_hs, r_hs, ar_pend, ar_pend_redir;
        logic [63:0] ar_pend_addr, ar_cap, b_addr;
        int          ar_cnt;
        ar_pend = 1'b0; ar_pend_redir = 1'b0; ar_pend_addr = '0; ar_cap = '0; b_addr = '0; ar_cnt = 0;
        arready = 1'b0; rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
        forever begin
            @(negedge clk);
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            if (!reset) begin
                if (arvalid && active) viol++;
                if (ar_pend && !arvalid) viol++;
                if (ar_pend && !ar_pend_redir && arvalid && araddr != ar_pend_addr) viol++;
            end
            ar_pend       = arvalid && !arready && !reset;
            ar_pend_addr  = araddr;
            ar_pend_redir = redirect_valid;
            if (ar_hs) begin
                ar_log.push_back(araddr);
                beats_at_ar.push_back(beats_total);
                ar_cap = araddr; last_len = arlen; last_size = arsize; last_burst = arburst; last_id = arid;
            end
            if (r_hs) beats_total++;
            @(posedge clk);
            #1;
            if (reset) begin
                active = 1'b0; b_beat = 0; ar_cnt = 0;
            end else begin
                if (r_hs) begin
                    b_beat++;
                    if (b_beat == BEATS) active = 1'b0;
                end
                if (ar_hs) begin
                    active = 1'b1; b_addr = ar_cap & ~64'(LB - 1); b_beat = 0; ar_cnt = 0;
                end
            end
            arready = arvalid && (ar_cnt >= ar_wait);
            if (arvalid && !arready) ar_cnt++;
            if (active) begin
                rvalid = 1'b1;
                rid    = '0;
                rdata  = {mem_word(b_addr + 64'(8 * b_beat) + 64'd4), mem_word(b_addr + 64'(8 * b_beat))};
                rresp  = (b_beat == err_beat) ? 2'b10 : 2'b00;
                rlast  = (b_beat == BEATS - 1);
            end else begin
                rvalid = 1'b0; rresp = 2'b00; rlast = 1'b0;
            end
        end
    end

    // Scoreboard side: every accepted instruction is popped and compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && inst_valid && inst_ready && !redirect_valid) begin
                accepts++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_inst: got pc 0x%0h inst 0x%0h, expected no instruction", inst_pc, inst);
                end else begin
                    e = sb.pop_front();
                    check("inst_pc", inst_pc, e.pc);
                    check("inst", 64'(inst), 64'(e.ins));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input logic [63:0] e);
        tick();
        reset = 1'b1; entry = e; inst_ready = 1'b0; redirect_valid = 1'b0;
        tick();
        tick();
        check("rst_arvalid", 64'(arvalid), 64'd0);
        check("rst_rready", 64'(rready), 64'd0);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_fault", 64'(fault), 64'd0);
        sb.delete(); ar_log.delete(); beats_at_ar.delete();
        accepts = 0; beats_total = 0;
        reset = 1'b0;
    endtask

    task automatic push_range(input logic [63:0] first, input int n);
        for (int k = 0; k < n; k++) sb.push_back('{pc: first + 64'(4 * k), ins: mem_word(first + 64'(4 * k))});
    endtask

    task automatic run_accepts(input int target);
        inst_ready = 1'b1;
        for (int c = 0; c < 300 && accepts < target; c++) tick();
        inst_ready = 1'b0;
        check("accept_count", 64'(accepts), 64'(target));
    endtask

    task automatic wait_ar(input int n);
        for (int c = 0; c < 100 && ar_log.size() < n; c++) tick();
        check("ar_count", 64'(ar_log.size()), 64'(n));
    endtask

    initial begin
        vec_t vecs[4];
        int   lat, seen;
        reset = 1'b1; entry = '0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        zero_addr = '1; err_beat = -1; ar_wait = 0;
        vecs[0] = '{64'h1000, 16, 64'h1000, 64'h1040, 0};
        vecs[1] = '{64'h2038,  2, 64'h2000, 64'h2040, 0};
        vecs[2] = '{64'h1020,  8, 64'h1000, 64'h1040, 1};
        vecs[3] = '{64'h3004, 15, 64'h3000, 64'h3040, 3};

        for (int i = 0; i < 4; i++) begin
            ar_wait = vecs[i].arwait;
            do_reset(vecs[i].entry);
            push_range(vecs[i].entry, vecs[i].n);
            lat = 0;
            for (int c = 1; c <= 60; c++) begin
                tick();
                if (inst_valid) begin lat = c; break; end
            end
            check("first_valid_cycle", 64'(lat), 64'(BEATS + 2 + vecs[i].arwait));
            run_accepts(vecs[i].n);
            wait_ar(2);
            if (ar_log.size() >= 2) begin
                check("araddr_first", ar_log[0], vecs[i].ar0);
                check("araddr_next", ar_log[1], vecs[i].ar1);
            end
            check("arlen", 64'(last_len), 64'd7);
            check("arsize", 64'(last_size), 64'd3);
            check("arburst", 64'(last_burst), 64'd1);
            check("arid", 64'(last_id), 64'd0);
            check("sb_empty", 64'(sb.size()), 64'd0);
            $display("[TB] vector %0d entry=0x%0h accepts=%0d latency=%0d", i, vecs[i].entry, accepts, lat);
        end
        ar_wait = 0;

        // Backpressure: 0x1008 must stay put with no new AR traffic.
        do_reset(64'h1000);
        push_range(64'h1000, 3);
        run_accepts(2);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_valid", 64'(inst_valid), 64'd1);
            check("bp_pc", inst_pc, 64'h1008);
            check("bp_inst", 64'(inst), 64'(mem_word(64'h1008)));
            check("bp_ar_count", 64'(ar_log.size()), 64'd1);
        end
        run_accepts(3);
        $display("[TB] backpressure sequence accepts=%0d", accepts);

        // Redirect that hits the resident line (low address bits must be ignored).
        do_reset(64'h1000);
        push_range(64'h1000, 1);
        run_accepts(1);
        check("hit_pre_pc", inst_pc, 64'h1004);
        redirect_valid = 1'b1; redirect_pc = 64'h1012; inst_ready = 1'b1;
        tick();
        redirect_valid = 1'b0; inst_ready = 1'b0;
        push_range(64'h1010, 12);
        run_accepts(13);
        check("hit_no_ar", 64'(ar_log.size()), 64'd1);
        wait_ar(2);
        if (ar_log.size() >= 2) check("hit_next_araddr", ar_log[1], 64'h1040);
        $display("[TB] redirect-hit sequence accepts=%0d", accepts);

        // Redirect that misses during fill beat 3: rest of the burst drained first.
        do_reset(64'h1000);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (active && b_beat == 2 && rvalid) break;
        end
        tick();
        redirect_valid = 1'b1; redirect_pc = 64'h3000;
        tick();
        redirect_valid = 1'b0;
        push_range(64'h3000, 1);
        wait_ar(2);
        if (ar_log.size() >= 2) begin
            check("miss_araddr", ar_log[1], 64'h3000);
            check("miss_beats_drained", 64'(beats_at_ar[1]), 64'd8);
        end
        run_accepts(1);
        $display("[TB] redirect-miss sequence ars=%0d accepts=%0d", ar_log.size(), accepts);

        // Error response on beat 5.
        err_beat = 5;
        do_reset(64'h1000);
        for (int c = 0; c < 40 && !fault; c++) tick();
        check("err_fault", 64'(fault), 64'd1);
        check("err_beats", 64'(beats_total), 64'd8);
        check("err_halted", 64'(halted), 64'd0);
        inst_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (inst_valid || arvalid) seen++;
        end
        inst_ready = 1'b0;
        check("err_idle_cycles_busy", 64'(seen), 64'd0);
        check("err_ar_count", 64'(ar_log.size()), 64'd1);
        err_beat = -1;
        $display("[TB] bus-error sequence fault=%0d beats=%0d", fault, beats_total);

        // Zero instruction word at 0x1008.
        zero_addr = 64'h1008;
        do_reset(64'h1000);
`ifdef IFETCH_HALT_ON_ZERO_EN
        push_range(64'h1000, 2);
        inst_ready = 1'b1;
        for (int c = 0; c < 60 && !halted; c++) tick();
        inst_ready = 1'b0;
        check("zero_halted", 64'(halted), 64'd1);
        check("zero_accepts", 64'(accepts), 64'd2);
        check("zero_inst_valid", 64'(inst_valid), 64'd0);
        check("zero_fault", 64'(fault), 64'd0);
`else
        push_range(64'h1000, 3);
        run_accepts(3);
        check("zero_halted", 64'(halted), 64'd0);
`endif
        zero_addr = '1;
        $display("[TB] zero-word sequence accepts=%0d halted=%0d", accepts, halted);

        check("protocol_violations", 64'(viol), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
